count_tracker: RTL
==================

# count_tracker

Sequence monitor for the load/up-down counter. It samples the counter's `count` bus each valid cycle, infers the count direction, and locks onto the sequence. It then flags illegal steps and reports wrap-around events. It sits on the consumer side of the counter interface, in the bench or in-system, as the reader of what the counter writes.

## Interface
- `WIDTH`, default 4: width of the observed count.
- `ERR_LIMIT`, default 3: consecutive bad steps that drop lock (1..15).
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `sample_valid`  in  1  `count_in` is meaningful this cycle.
- `count_in`  in  WIDTH  observed counter value.
- `load_in`  in  1  qualifies this sample as a legal load (arbitrary jump).
- `locked`  out  1  tracker is locked to an up or down sequence.
- `dir_out`  out  1  1 = counting up, 0 = counting down; valid when `locked`.
- `step_err`  out  1  one-cycle pulse on an illegal step while locked.
- `wrap_pulse`  out  1  one-cycle pulse on max→0 (up) or 0→max (down).
- `err_count`  out  8  saturating total of `step_err` pulses.
- `wrap_count`  out  8  modulo-256 total of `wrap_pulse`.

## Operation
- State machine: UNLOCKED, LOCKED_UP, LOCKED_DOWN. Internal registers: `prev` (WIDTH), `have_prev`, `consec_err` (4 bits).
- A step is classified from `prev` to `count_in`, with all arithmetic modulo 2^WIDTH:
  - UP: `count_in` == `prev`+1.
  - DOWN: `count_in` == `prev`−1.
  - SAME: `count_in` == `prev`.
  - JUMP: any other value.
- Cycles with `sample_valid`=0 change nothing, and all pulses are 0.
- UNLOCKED:
  - No `have_prev`: store `prev`, set `have_prev`.
  - Otherwise UP goes to LOCKED_UP and DOWN goes to LOCKED_DOWN. SAME or JUMP stays in UNLOCKED.
  - `prev` always updates.
  - No `step_err` is raised while UNLOCKED.
- LOCKED_UP:
  - `load_in`=1: accept any value and clear `consec_err`. There is no wrap check. `load_in` takes priority over classification.
  - UP: OK. Clear `consec_err`. If `prev`=2^WIDTH−1, pulse `wrap_pulse`.
  - DOWN: legal reversal. Go to LOCKED_DOWN, clear `consec_err`, no error. A wrap check applies as in the down direction.
  - SAME/JUMP: pulse `step_err`, increment `err_count` (saturates at 255), increment `consec_err`. When `consec_err` reaches `ERR_LIMIT`, go to UNLOCKED, clear `have_prev` and `consec_err`.
- LOCKED_DOWN: mirror of LOCKED_UP with UP/DOWN swapped. Wrap is `prev`=0 → `count_in`=2^WIDTH−1.
- `prev` updates on every valid sample in every state, including error samples.
- `locked` = state ≠ UNLOCKED. `dir_out` = 1 in LOCKED_UP, 0 in LOCKED_DOWN, and holds its last value in UNLOCKED.

## Timing
- All outputs are registered. The response to the sample at edge N is visible after edge N+1, so latency is 1 cycle.
- `step_err` and `wrap_pulse` are high for exactly one cycle per causing sample. Back-to-back valid samples give back-to-back pulses.
- Reset values: state UNLOCKED, `locked`=0, `dir_out`=1, `step_err`=0, `wrap_pulse`=0, `err_count`=0, `wrap_count`=0, `prev`=0, `have_prev`=0.
- Reset takes effect immediately and asynchronously, including mid-sequence. Release is synchronous to `clk`. The first valid sample after release only seeds `prev`.
- Lock is acquired 2 valid samples after reset. Lock loss happens on the `ERR_LIMIT`-th consecutive bad sample, in the same cycle that `step_err` is asserted.

## Configuration
- `COUNT_TRACKER_STATS_EN`:
  - Defined: `err_count` and `wrap_count` registers are built as described.
  - Undefined: both ports remain but are tied to 0, and no counter flops exist.
- `step_err`, `wrap_pulse`, `locked` and `dir_out` are unaffected either way.

## Structure
- Package `count_tracker_pkg` holds:
  - the state enum (UNLOCKED, LOCKED_UP, LOCKED_DOWN);
  - the step-class enum (UP, DOWN, SAME, JUMP);
  - the constant `STAT_W`=8.
- Sub-module `step_classify` is purely combinational. Inputs: `prev`, `count_in`. Outputs: the step class, `is_max_prev`, `is_zero_prev`.
- The top contains the FSM, the `prev`/`consec_err` registers, and the conditional stats counters.

## Test plan
- Reset, then valid 3,4,5 → `locked`=1 after the 4, `dir_out`=1, no `step_err`.
- Locked up, valid 14,15,0,1 → `wrap_pulse` once, after the 0. `wrap_count`=1.
- Locked up at 7, valid 6,5 → `dir_out`=0, `locked` stays 1, `step_err` never asserts.
- Locked up at 5, valid 9,9,2 with `ERR_LIMIT`=3 → three `step_err` pulses, `err_count`=3, `locked`=0 after the third.
- Locked up at 5, valid 12 with `load_in`=1, then 13 → no `step_err`, still LOCKED_UP.
- Assert `rst` low mid-sequence for one cycle → all outputs return to reset values. The next two valid samples 8,7 relock with `dir_out`=0.

Source files
------------

// File: rtl/count_tracker_pkg.sv
// count_tracker_pkg: shared state/step encodings and stats width for count_tracker.
// Rev 1.0
`default_nettype none

package count_tracker_pkg;

  localparam int STAT_W = 8;

  typedef enum logic [1:0] {
    UNLOCKED    = 2'd0,
    LOCKED_UP   = 2'd1,
    LOCKED_DOWN = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    UP   = 2'd0,
    DOWN = 2'd1,
    SAME = 2'd2,
    JUMP = 2'd3
  } step_t;

endpackage

`default_nettype wire

// File: rtl/step_classify.sv
// step_classify: combinational prev -> count_in step classifier (modulo 2^WIDTH).
// Rev 1.0
`default_nettype none

module step_classify
  import count_tracker_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] prev,
  input  logic [WIDTH-1:0] count_in,
  output step_t            step,
  output logic             is_max_prev,
  output logic             is_zero_prev
);

  logic [WIDTH-1:0] prev_inc;
  logic [WIDTH-1:0] prev_dec;

  assign prev_inc = prev + WIDTH'(1);
  assign prev_dec = prev - WIDTH'(1);

  // UP is tested first so a 1-bit counter (where +1 == -1) reads as UP.
  always_comb begin
    step = JUMP;
    if (count_in == prev_inc) begin
      step = UP;
    end else if (count_in == prev_dec) begin
      step = DOWN;
    end else if (count_in == prev) begin
      step = SAME;
    end
  end

  assign is_max_prev  = &prev;
  assign is_zero_prev = ~|prev;

endmodule

`default_nettype wire

// File: rtl/count_tracker.sv
// count_tracker: locks onto an up/down count sequence, flags bad steps and wraps.
// Rev 1.0. Optional err/wrap statistics counters built only with COUNT_TRACKER_STATS_EN.
`default_nettype none

module count_tracker
  import count_tracker_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int ERR_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic [WIDTH-1:0]  count_in,
  input  logic              load_in,
  output logic              locked,
  output logic              dir_out,
  output logic              step_err,
  output logic              wrap_pulse,
  output logic [STAT_W-1:0] err_count,
  output logic [STAT_W-1:0] wrap_count
);

  localparam logic [3:0] LIMIT = 4'(ERR_LIMIT);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] prev, prev_nxt;
  logic             have_prev, have_prev_nxt;
  logic [3:0]       consec_err, consec_err_nxt;
  logic             dir_nxt;
  logic             step_err_nxt;
  logic             wrap_nxt;
  logic             bad_step;
  logic [3:0]       consec_inc;

  step_t step;
  logic  is_max_prev;
  logic  is_zero_prev;

  step_classify #(
    .WIDTH (WIDTH)
  ) u_classify (
    .prev         (prev),
    .count_in     (count_in),
    .step         (step),
    .is_max_prev  (is_max_prev),
    .is_zero_prev (is_zero_prev)
  );

  assign consec_inc = consec_err + 4'd1;

  always_comb begin
    state_nxt      = state;
    prev_nxt       = prev;
    have_prev_nxt  = have_prev;
    consec_err_nxt = consec_err;
    dir_nxt        = dir_out;
    step_err_nxt   = 1'b0;
    wrap_nxt       = 1'b0;
    bad_step       = 1'b0;

    if (sample_valid) begin
      prev_nxt = count_in;
      case (state)
        UNLOCKED: begin
          if (!have_prev) begin
            have_prev_nxt = 1'b1;
          end else if (step == UP) begin
            state_nxt = LOCKED_UP;
            dir_nxt   = 1'b1;
          end else if (step == DOWN) begin
            state_nxt = LOCKED_DOWN;
            dir_nxt   = 1'b0;
          end
        end
        LOCKED_UP: begin
          if (load_in) begin
            consec_err_nxt = 4'd0;
          end else if (step == UP) begin
            consec_err_nxt = 4'd0;
            wrap_nxt       = is_max_prev;
          end else if (step == DOWN) begin
            state_nxt      = LOCKED_DOWN;
            dir_nxt        = 1'b0;
            consec_err_nxt = 4'd0;
            wrap_nxt       = is_zero_prev;
          end else begin
            bad_step = 1'b1;
          end
        end
        LOCKED_DOWN: begin
          if (load_in) begin
            consec_err_nxt = 4'd0;
          end else if (step == DOWN) begin
            consec_err_nxt = 4'd0;
            wrap_nxt       = is_zero_prev;
          end else if (step == UP) begin
            state_nxt      = LOCKED_UP;
            dir_nxt        = 1'b1;
            consec_err_nxt = 4'd0;
            wrap_nxt       = is_max_prev;
          end else begin
            bad_step = 1'b1;
          end
        end
        default: begin
          state_nxt = UNLOCKED;
        end
      endcase

      // Lock drops on the same sample that raises the ERR_LIMIT-th error.
      if (bad_step) begin
        step_err_nxt = 1'b1;
        if (consec_inc >= LIMIT) begin
          state_nxt      = UNLOCKED;
          have_prev_nxt  = 1'b0;
          consec_err_nxt = 4'd0;
        end else begin
          consec_err_nxt = consec_inc;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= UNLOCKED;
      prev       <= '0;
      have_prev  <= 1'b0;
      consec_err <= 4'd0;
      dir_out    <= 1'b1;
      step_err   <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      prev       <= prev_nxt;
      have_prev  <= have_prev_nxt;
      consec_err <= consec_err_nxt;
      dir_out    <= dir_nxt;
      step_err   <= step_err_nxt;
      wrap_pulse <= wrap_nxt;
    end
  end

  assign locked = (state != UNLOCKED);

`ifdef COUNT_TRACKER_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_count  <= '0;
      wrap_count <= '0;
    end else begin
      if (step_err_nxt && (err_count != {STAT_W{1'b1}})) begin
        err_count <= err_count + STAT_W'(1);
      end
      if (wrap_nxt) begin
        wrap_count <= wrap_count + STAT_W'(1);
      end
    end
  end
`else
  assign err_count  = '0;
  assign wrap_count = '0;
`endif

endmodule

`default_nettype wire
